sad_min_tracker: RTL and testbench
==================================

# sad_min_tracker

Downstream consumer of the motion-estimation control stage. Takes the pixel stream that stage produces (current pixel `c`, two reference candidates `p` and `p_prime`, qualified by `start`), accumulates two 16-pixel SADs in parallel, and keeps a running minimum over all candidates of one search. Presents the winning SAD and candidate index with a one-cycle `done` pulse.

## Interface
- `NUM_PAIRS`, 256: candidate pairs per search; each pair is 16 beats.
- `LEAD`, 2: cycles discarded after `start` rises, covering the upstream pipeline fill.
- `CAND_W`, 9: width of `best_idx`; must satisfy 2^CAND_W >= 2*NUM_PAIRS.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (low) clears all state immediately.
- `start` in 1: high while the upstream stage is streaming.
- `c` in 8: current-block pixel.
- `p` in 8: reference pixel, even candidate.
- `p_prime` in 8: reference pixel, odd candidate.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a search completes.
- `best_sad` out 12: minimum SAD of the last completed search.
- `best_idx` out CAND_W: candidate index of `best_sad`.

## Operation
- States:
  - IDLE
  - LEAD: counts LEAD cycles.
  - ACCUM: beats of pair 0..NUM_PAIRS-1.
  - FLUSH: final compare.
  - DONE: one cycle.
- IDLE to LEAD on a rising edge of `start`, i.e. `start` high with the registered `start_q` low. A `start` that is already high on reset exit does not launch a search.
- On leaving IDLE, the running minimum `min_sad` is set to 12'hFFF and `min_idx` to 0.
- LEAD to ACCUM after exactly LEAD cycles.
- ACCUM keeps a 4-bit beat counter and a pair counter. Per beat:
  - d_a = |c - p| and d_b = |c - p_prime|, each 8-bit unsigned computed at 9-bit precision.
  - Beat 0 loads `acc_a <= d_a` and `acc_b <= d_b`; beats 1..15 add to the accumulators. Accumulators are 12 bits and cannot overflow (16*255 = 4080).
  - At beat 15, the final sums `acc + d` are latched into `sad_a_q` and `sad_b_q` with the pair number `k`. A compare-pending flag is set.
- Compare runs in the cycle after beat 15, overlapping beat 0 of the next pair:
  - If sad_a_q <= sad_b_q and sad_a_q < min_sad: min <= (sad_a_q, 2k).
  - Else if sad_b_q < min_sad: min <= (sad_b_q, 2k+1).
  - Ties between the pair go to the even candidate. Ties with the current minimum keep the earlier candidate.
- After beat 15 of pair NUM_PAIRS-1, ACCUM goes to FLUSH, which performs the last compare.
- FLUSH goes to DONE. In DONE, `best_sad`/`best_idx` load the final minimum and `done` is high. DONE returns to IDLE next cycle.
- Abort: if `start` falls in LEAD, ACCUM or FLUSH, the block returns to IDLE next cycle.
  - No `done` pulse.
  - `best_sad`/`best_idx` keep the previous search's result.
  - The partial minimum is discarded.
- `start` high during DONE or IDLE without a rising edge is ignored.
- Reset values: `busy` 0, `done` 0, `best_sad` 0, `best_idx` 0, state IDLE, all counters and accumulators 0.

## Timing
- Let `start` first be sampled high at cycle T.
  - Beats of pair k occupy T+LEAD+16k … T+LEAD+16k+15.
  - Pair k is compared in cycle T+LEAD+16k+16.
- FLUSH is cycle T+LEAD+16*NUM_PAIRS. `done` and the new `best_*` values are visible in cycle T+LEAD+16*NUM_PAIRS+1.
- With defaults, `done` appears 4099 cycles after T.
- `best_*` change only in DONE and are stable otherwise.
- `busy` rises the cycle after T and falls the cycle after DONE.
- Input to accumulator latency is 1 cycle; there is no backpressure. Inputs are sampled every cycle in ACCUM.
- Reset asserted mid-search clears all outputs asynchronously, without waiting for a clock edge. Operation resumes only on a fresh `start` rising edge after release.

## Test plan
- Constant stream: c=p=p_prime=8'h40 for a full search. Required: `done` once at T+4099, best_sad=0, best_idx=0.
- Single-candidate target: `p` differs from `c` by 1 except pair 37, where p==c; `p_prime` differs by 2 everywhere. Required: best_sad=0, best_idx=74.
- Odd winner and ties:
  - Every beat of pair 5 has |c-p|=3 and |c-p_prime|=1; all other pairs have both diffs at 4. Required: best_sad=16, best_idx=11.
  - Same stimulus with equal diffs of 1 in pair 5. Required: best_idx=10.
- Extremes: c=8'hFF with p=p_prime=0 everywhere. Required: best_sad=4080 (12'hFF0), best_idx=0, no wrap.
- Abort: drop `start` at beat 7 of pair 100 after a completed search that gave best_sad=16. Required: no `done`, best_sad still 16, `busy` 0 one cycle later. A new rising edge then runs a normal search.
- Reset mid-run: pull `reset` low at pair 50. Required: `busy`, `done`, `best_sad` and `best_idx` all go to 0 immediately. With `start` held high through release, no search starts until `start` toggles low then high.

Source files
------------

// File: rtl/sad_min_tracker.sv
// Dual 16-pixel SAD accumulator that keeps a running minimum over all candidate
// pairs of a search and reports the winning SAD and candidate index.
module sad_min_tracker #(
  parameter int unsigned NUM_PAIRS = 256,
  parameter int unsigned LEAD      = 2,
  parameter int unsigned CAND_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        c,
  input  logic [7:0]        p,
  input  logic [7:0]        p_prime,
  output logic              busy,
  output logic              done,
  output logic [11:0]       best_sad,
  output logic [CAND_W-1:0] best_idx
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SAD_W  = 12;
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned LEAD_W = $clog2(LEAD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                start_q;
  logic [LEAD_W-1:0]   lead_cnt_q, lead_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [SAD_W-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [SAD_W-1:0]    sad_a_q, sad_a_d, sad_b_q, sad_b_d;
  logic [PAIR_W-1:0]   sad_k_q, sad_k_d;
  logic                cmp_pend_q, cmp_pend_d;
  logic [SAD_W-1:0]    min_sad_q, min_sad_d;
  logic [CAND_W-1:0]   min_idx_q, min_idx_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [SAD_W-1:0]    best_sad_q, best_sad_d;
  logic [CAND_W-1:0]   best_idx_q, best_idx_d;

  logic [PIX_W:0]      diff_a_c, diff_b_c;
  logic [PIX_W-1:0]    d_a_c, d_b_c;
  logic [SAD_W-1:0]    upd_sad_c;
  logic [CAND_W-1:0]   upd_idx_c;

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

  // Absolute differences taken at 9-bit precision so the borrow gives the sign.
  always_comb begin
    diff_a_c = {1'b0, c} - {1'b0, p};
    diff_b_c = {1'b0, c} - {1'b0, p_prime};
    d_a_c    = diff_a_c[PIX_W] ? PIX_W'(-diff_a_c) : diff_a_c[PIX_W-1:0];
    d_b_c    = diff_b_c[PIX_W] ? PIX_W'(-diff_b_c) : diff_b_c[PIX_W-1:0];
  end

  // Pending pair compare; ties favour the even candidate, then the older minimum.
  always_comb begin
    upd_sad_c = min_sad_q;
    upd_idx_c = min_idx_q;
    if (cmp_pend_q) begin
      if ((sad_a_q <= sad_b_q) && (sad_a_q < min_sad_q)) begin
        upd_sad_c = sad_a_q;
        upd_idx_c = CAND_W'({sad_k_q, 1'b0});
      end else if (sad_b_q < min_sad_q) begin
        upd_sad_c = sad_b_q;
        upd_idx_c = CAND_W'({sad_k_q, 1'b1});
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lead_cnt_d = lead_cnt_q;
    beat_d     = beat_q;
    pair_d     = pair_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    sad_a_d    = sad_a_q;
    sad_b_d    = sad_b_q;
    sad_k_d    = sad_k_q;
    cmp_pend_d = cmp_pend_q;
    min_sad_d  = min_sad_q;
    min_idx_d  = min_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          // The IDLE cycle that sees the edge is the first discarded lead cycle.
          state_d    = S_LEAD;
          lead_cnt_d = LEAD_W'(1);
          beat_d     = '0;
          pair_d     = '0;
          cmp_pend_d = 1'b0;
          min_sad_d  = {SAD_W{1'b1}};
          min_idx_d  = '0;
        end
      end
      S_LEAD: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (lead_cnt_q >= LEAD_W'(LEAD - 1)) begin
          state_d = S_ACCUM;
        end else begin
          lead_cnt_d = lead_cnt_q + LEAD_W'(1);
        end
      end
      S_ACCUM: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          min_sad_d  = upd_sad_c;
          min_idx_d  = upd_idx_c;
          cmp_pend_d = 1'b0;
          if (beat_q == '0) begin
            acc_a_d = SAD_W'(d_a_c);
            acc_b_d = SAD_W'(d_b_c);
          end else begin
            acc_a_d = acc_a_q + SAD_W'(d_a_c);
            acc_b_d = acc_b_q + SAD_W'(d_b_c);
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == {BEAT_W{1'b1}}) begin
            sad_a_d    = acc_a_d;
            sad_b_d    = acc_b_d;
            sad_k_d    = pair_q;
            cmp_pend_d = 1'b1;
            if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
              state_d = S_FLUSH;
              pair_d  = '0;
            end else begin
              pair_d = pair_q + PAIR_W'(1);
            end
          end
        end
      end
      S_FLUSH: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_DONE;
          min_sad_d  = upd_sad_c;
          min_idx_d  = upd_idx_c;
          cmp_pend_d = 1'b0;
          best_sad_d = upd_sad_c;
          best_idx_d = upd_idx_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      // Treated as already high so a start held across reset release is no edge.
      start_q    <= 1'b1;
      lead_cnt_q <= '0;
      beat_q     <= '0;
      pair_q     <= '0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      sad_a_q    <= '0;
      sad_b_q    <= '0;
      sad_k_q    <= '0;
      cmp_pend_q <= 1'b0;
      min_sad_q  <= '0;
      min_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      lead_cnt_q <= lead_cnt_d;
      beat_q     <= beat_d;
      pair_q     <= pair_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      sad_a_q    <= sad_a_d;
      sad_b_q    <= sad_b_d;
      sad_k_q    <= sad_k_d;
      cmp_pend_q <= cmp_pend_d;
      min_sad_q  <= min_sad_d;
      min_idx_q  <= min_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: table of whole-search patterns with a result
// scoreboard, plus abort and mid-search reset sequences.
module tb_sad_min_tracker;

  localparam int NP     = 256;
  localparam int LD     = 2;
  localparam int BEATS  = NP * 16;
  localparam int DONE_N = LD + BEATS;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  c, p, p_prime;
  logic        busy, done;
  logic [11:0] best_sad;
  logic [8:0]  best_idx;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_sad;
  logic [8:0]  last_idx;

  typedef struct {
    int          pat;
    logic [11:0] sad;
    logic [8:0]  idx;
  } vec_t;

  typedef struct {
    logic [11:0] sad;
    logic [8:0]  idx;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  sad_min_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .c        (c),
    .p        (p),
    .p_prime  (p_prime),
    .busy     (busy),
    .done     (done),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pixel pattern generator: beat b of pair k for each pattern id.
  task automatic get_beat(input int pat, input int k, input int b,
                          output logic [7:0] cv, output logic [7:0] pv, output logic [7:0] qv);
    cv = 8'h00; pv = 8'h00; qv = 8'h00;
    case (pat)
      0: begin cv = 8'h40; pv = 8'h40; qv = 8'h40; end
      1: begin
        cv = 8'(128 + b);
        pv = (k == 37) ? cv : 8'(128 + b + 1);
        qv = 8'(128 + b - 2);
      end
      2, 3: begin
        cv = 8'(48 + 4 * b);
        if (k == 5 && pat == 2) begin
          pv = 8'(48 + 4 * b - 3); qv = 8'(48 + 4 * b + 1);
        end else if (k == 5) begin
          pv = 8'(48 + 4 * b + 1); qv = 8'(48 + 4 * b - 1);
        end else if (b % 2 == 1) begin
          pv = 8'(48 + 4 * b - 4); qv = 8'(48 + 4 * b + 4);
        end else begin
          pv = 8'(48 + 4 * b + 4); qv = 8'(48 + 4 * b - 4);
        end
      end
      4: begin cv = 8'hFF; pv = 8'h00; qv = 8'h00; end
      default: begin
        cv = 8'((k * 7 + b * 13) ^ 90);
        pv = 8'(k * 3 + b * 29 + 17);
        qv = 8'(255 - k - b * 5);
      end
    endcase
  endtask

  task automatic model_search(input int pat, output logic [11:0] s, output logic [8:0] i);
    int mn, mi, sa, sb, da, db;
    logic [7:0] cv, pv, qv;
    mn = 4095; mi = 0;
    for (int k = 0; k < NP; k++) begin
      sa = 0; sb = 0;
      for (int b = 0; b < 16; b++) begin
        get_beat(pat, k, b, cv, pv, qv);
        da = int'(cv) - int'(pv);
        db = int'(cv) - int'(qv);
        sa += (da < 0) ? -da : da;
        sb += (db < 0) ? -db : db;
      end
      if (sa <= sb && sa < mn) begin mn = sa; mi = 2 * k; end
      else if (sb < mn) begin mn = sb; mi = 2 * k + 1; end
    end
    s = 12'(mn);
    i = 9'(mi);
  endtask

  task automatic drive_beat(input int pat, input int m);
    logic [7:0] cv, pv, qv;
    if (m >= 0 && m < BEATS) begin
      get_beat(pat, m / 16, m % 16, cv, pv, qv);
      c = cv; p = pv; p_prime = qv;
    end else begin
      c = 8'h00; p = 8'h00; p_prime = 8'h00;
    end
  endtask

  // Full search; entered and left on a falling clock edge.
  task automatic run_search(input int pat, input logic [11:0] es, input logic [8:0] ei);
    int   done_cnt, done_at;
    exp_t e;
    done_cnt = 0; done_at = -1;
    chk("busy_idle_pre", 32'(busy), 0);
    start = 1'b1;
    drive_beat(pat, -LD);
    e.sad = es; e.idx = ei;
    sb_q.push_back(e);
    for (int n = 0; n <= DONE_N + 7; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at = n;
        chk("sb_nonempty_at_done", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("best_sad", 32'(best_sad), 32'(e.sad));
          chk("best_idx", 32'(best_idx), 32'(e.idx));
        end
      end
      if (n == 0) chk("busy_rise", 32'(busy), 1);
      if (n == DONE_N - 1) begin
        chk("done_early", 32'(done), 0);
        chk("best_sad_stable", 32'(best_sad), 32'(last_sad));
        chk("best_idx_stable", 32'(best_idx), 32'(last_idx));
      end
      if (n == DONE_N) chk("busy_in_done", 32'(busy), 1);
      if (n == DONE_N + 2) chk("busy_start_held_idle", 32'(busy), 0);
      if (n == DONE_N + 5) chk("busy_after_search", 32'(busy), 0);
      if (n + 1 >= DONE_N + 4) start = 1'b0;
      drive_beat(pat, n + 1 - LD);
    end
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_at), 32'(DONE_N));
    chk("sb_drained", 32'(sb_q.size()), 0);
    sb_q.delete();
    last_sad = es;
    last_idx = ei;
  endtask

  // Drop start at beat 7 of pair 100.
  task automatic run_abort();
    int done_cnt, abort_n;
    done_cnt = 0;
    abort_n  = LD + 100 * 16 + 7;
    start = 1'b1;
    drive_beat(0, -LD);
    for (int n = 0; n <= abort_n + 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
      if (n == abort_n - 1) chk("abort_busy_before", 32'(busy), 1);
      if (n == abort_n) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_best_sad", 32'(best_sad), 32'(last_sad));
        chk("abort_best_idx", 32'(best_idx), 32'(last_idx));
      end
      if (n + 1 == abort_n) start = 1'b0;
      if (start) drive_beat(0, n + 1 - LD);
    end
    chk("abort_no_done", 32'(done_cnt), 0);
  endtask

  // Reset at pair 50 with start held high through release.
  task automatic run_reset();
    int busy_cnt;
    start = 1'b1;
    drive_beat(0, -LD);
    for (int n = 0; n < LD + 50 * 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      drive_beat(0, n + 1 - LD);
    end
    chk("rst_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_best_sad", 32'(best_sad), 0);
    chk("rst_best_idx", 32'(best_idx), 0);
    last_sad = 12'd0;
    last_idx = 9'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("rst_no_relaunch", 32'(busy_cnt), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [11:0] ms;
    logic [8:0]  mi;
    reset = 1'b0;
    start = 1'b0;
    c = 8'h00; p = 8'h00; p_prime = 8'h00;
    last_sad = 12'd0;
    last_idx = 9'd0;

    model_search(5, ms, mi);
    vecs[0] = '{0, 12'd0,    9'd0};
    vecs[1] = '{1, 12'd0,    9'd74};
    vecs[2] = '{3, 12'd16,   9'd10};
    vecs[3] = '{4, 12'hFF0,  9'd0};
    vecs[4] = '{5, ms,       mi};
    vecs[5] = '{2, 12'd16,   9'd11};

    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_best_sad", 32'(best_sad), 0);
    chk("reset_best_idx", 32'(best_idx), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_search(vecs[i].pat, vecs[i].sad, vecs[i].idx);

    run_abort();
    repeat (3) @(negedge clk);
    run_search(4, 12'hFF0, 9'd0);
    run_reset();
    run_search(1, 12'd0, 9'd74);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
